// File: rtl/spi_peripheral.sv
// SPI responder (target side). Pins are oversampled in the clock domain.
// 8-bit frames are shifted MSB-first. Local logic sees a one-entry
// valid/ready transmit buffer and a one-cycle received-byte strobe.
module spi_peripheral #(
    parameter bit         CPOL      = 1'b0,
    parameter bit         CPHA      = 1'b0,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sclk,
    input  logic       cs,
    input  logic       pico,
    output logic       poci,
    output logic       poci_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    // Bits [0] and [1] form the synchronizer; bit [2] is the delayed copy
    // that stage 2 is compared against for edge detection.
    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [1:0] pico_q;

    logic       sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic       sample_edge, shift_edge;
    logic       cs_fall, cs_rise;

    logic [1:0] state;
    logic       buf_full;
    logic [7:0] buf_data;
    logic [7:0] load_byte;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [2:0] bit_cnt;
    logic       rx_done;
    logic       first;

    // Synchronize the asynchronous pins and keep one extra stage for edges.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sclk_q <= {3{CPOL}};
            cs_q   <= 3'b111;
            pico_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            cs_q   <= {cs_q[1:0], cs};
            pico_q <= {pico_q[0], pico};
        end
    end

    assign sclk_rise   =  sclk_q[1] & ~sclk_q[2];
    assign sclk_fall   = ~sclk_q[1] &  sclk_q[2];
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = ~cs_q[1] &  cs_q[2];
    assign cs_rise     =  cs_q[1] & ~cs_q[2];

    assign tx_ready  = !buf_full;
    assign load_byte = buf_full ? buf_data : IDLE_BYTE;

    // Frame FSM, transmit buffer and shift registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_IDLE;
            buf_full    <= 1'b0;
            buf_data    <= 8'h00;
            tx_shift    <= 8'h00;
            rx_shift    <= 8'h00;
            bit_cnt     <= 3'd0;
            rx_done     <= 1'b0;
            first       <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            poci        <= 1'b1;
            poci_oe     <= 1'b0;
        end else begin
            rx_valid    <= rx_done;
            rx_done     <= 1'b0;
            tx_underrun <= 1'b0;
            if (rx_done)
                rx_data <= rx_shift;

            // The load looks at the buffer as it stood at the start of the
            // cycle, so a byte accepted during LOAD waits for the next load.
            if (tx_valid && !buf_full) begin
                buf_full <= 1'b1;
                buf_data <= tx_data;
            end else if (state == ST_LOAD && buf_full) begin
                buf_full <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    poci_oe <= 1'b0;
                    if (cs_fall) begin
                        state <= ST_LOAD;
                        first <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    tx_shift    <= load_byte;
                    tx_underrun <= !buf_full;
                    bit_cnt     <= 3'd0;
                    poci_oe     <= 1'b1;
                    first       <= 1'b0;
                    state       <= ST_SHIFT;
                    // Back-to-back CPHA=0 bytes wait for the trailing edge.
                    if (!CPHA && first)
                        poci <= load_byte[7];
                end
                ST_SHIFT: begin
                    if (sample_edge) begin
                        rx_shift <= {rx_shift[6:0], pico_q[1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_done <= 1'b1;
                            state   <= ST_LOAD;
                        end
                    end
                    // The first shift edge of a byte presents its MSB.
                    if (shift_edge) begin
                        if (bit_cnt == 3'd0) begin
                            poci <= tx_shift[7];
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            poci     <= tx_shift[6];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Deselect aborts any frame; a byte finishing this cycle still
            // completes because rx_done is already set above.
            if (cs_rise && state != ST_IDLE) begin
                state   <= ST_IDLE;
                poci_oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: mode 0 and mode 3 instances side by side,
// driven by a bit-level SPI controller model with ten clocks per sclk period.
module tb_spi_peripheral;

    logic       clock;
    logic [1:0] rst_n, sclk, cs, pico, poci, poci_oe;
    logic [1:0] tx_valid, tx_ready, rx_valid, tx_underrun;
    logic [7:0] tx_data [2];
    logic [7:0] rx_data [2];

    int n_cmp, n_bad;
    int rxn [2];
    int urn [2];
    logic [7:0] rxlog [2][64];

    // frame descriptor: controller bytes, buffer bytes, and what came back
    int         f_n;
    logic [7:0] f_ctrl [4];
    logic [7:0] f_data [4];
    bit         f_have [4];
    logic [7:0] f_got  [4];
    bit         f_lp;
    logic [7:0] f_lpb;

    spi_peripheral #(.CPOL(1'b0), .CPHA(1'b0), .IDLE_BYTE(8'hFF)) u_m0 (
        .clock(clock), .reset(rst_n[0]), .sclk(sclk[0]), .cs(cs[0]), .pico(pico[0]),
        .poci(poci[0]), .poci_oe(poci_oe[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .tx_underrun(tx_underrun[0]));

    spi_peripheral #(.CPOL(1'b1), .CPHA(1'b1), .IDLE_BYTE(8'hFF)) u_m3 (
        .clock(clock), .reset(rst_n[1]), .sclk(sclk[1]), .cs(cs[1]), .pico(pico[1]),
        .poci(poci[1]), .poci_oe(poci_oe[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .tx_underrun(tx_underrun[1]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // log received bytes and underrun pulses away from the active edge
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (rx_valid[i] === 1'b1) begin
                rxlog[i][rxn[i] % 64] <= rx_data[i];
                rxn[i] <= rxn[i] + 1;
            end
            if (tx_underrun[i] === 1'b1)
                urn[i] <= urn[i] + 1;
        end
    end

    task automatic half(input int m, input bit pe, input logic [7:0] pb);
        if (pe) begin
            tx_valid[m] = 1'b1;
            tx_data[m]  = pb;
        end
        for (int j = 0; j < 5; j++) begin
            @(posedge clock); #1;
            tx_valid[m] = 1'b0;
        end
    endtask

    task automatic push(input int m, input logic [7:0] b);
        int t;
        t = 0;
        while (tx_ready[m] !== 1'b1 && t < 50) begin
            @(posedge clock); #1;
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL push_timeout m%0d: tx_ready stayed %b, want 1", m, tx_ready[m]);
        end
        tx_valid[m] = 1'b1;
        tx_data[m]  = b;
        @(posedge clock); #1;
        tx_valid[m] = 1'b0;
    endtask

    // one controller frame of f_n bytes; cs rises together with the last sample edge
    task automatic frame(input int m);
        bit cp;
        bit last;
        cp = (m == 1);
        if (f_have[0]) push(m, f_data[0]);
        cs[m] = 1'b0;
        if (!cp) pico[m] = f_ctrl[0][7];
        for (int j = 0; j < 5; j++) begin
            @(posedge clock); #1;
            if (f_lp && j == 2) begin
                tx_valid[m] = 1'b1;
                tx_data[m]  = f_lpb;
            end else begin
                tx_valid[m] = 1'b0;
            end
        end
        for (int k = 0; k < f_n; k++) begin
            for (int i = 7; i >= 0; i--) begin
                last = (k == f_n - 1) && (i == 0);
                sclk[m] = ~cp;
                if (!cp) begin
                    f_got[k][i] = poci[m];
                    if (last) cs[m] = 1'b1;
                end else begin
                    pico[m] = f_ctrl[k][i];
                end
                half(m, (i == 7) && (k + 1 < f_n) && f_have[k + 1], f_data[(k + 1) % 4]);
                sclk[m] = cp;
                if (cp) begin
                    f_got[k][i] = poci[m];
                    if (last) cs[m] = 1'b1;
                end else if (!last) begin
                    pico[m] = (i > 0) ? f_ctrl[k][i - 1] : f_ctrl[k + 1][7];
                end
                half(m, 1'b0, 8'h00);
            end
        end
        cs[m]   = 1'b1;
        sclk[m] = cp;
        half(m, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        rst_n = 2'b00;
        repeat (4) @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({rx_data[i], rx_valid[i], tx_ready[i], tx_underrun[i], poci[i], poci_oe[i]} !== {8'h00, 5'b01010}) begin
                n_bad++;
                $display("FAIL reset_outputs m%0d: got rx=%h v=%b rdy=%b un=%b poci=%b oe=%b want 00 0 1 0 1 0",
                         i, rx_data[i], rx_valid[i], tx_ready[i], tx_underrun[i], poci[i], poci_oe[i]);
            end
        end
        rst_n = 2'b11;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic test_mode0_basic();
        int rb, ub;
        rb = rxn[0]; ub = urn[0];
        f_n = 1; f_have[0] = 1; f_data[0] = 8'hA5; f_ctrl[0] = 8'h3C; f_lp = 0;
        frame(0);
        n_cmp++; if (f_got[0] !== 8'hA5) begin n_bad++; $display("FAIL m0_ctrl_rx: got %h want a5", f_got[0]); end
        n_cmp++; if (rxn[0] - rb !== 1) begin n_bad++; $display("FAIL m0_rx_pulses: got %0d want 1", rxn[0] - rb); end
        n_cmp++; if (rxlog[0][rb % 64] !== 8'h3C) begin n_bad++; $display("FAIL m0_rx_byte: got %h want 3c", rxlog[0][rb % 64]); end
        n_cmp++; if (rx_data[0] !== 8'h3C) begin n_bad++; $display("FAIL m0_rx_hold: got %h want 3c", rx_data[0]); end
        n_cmp++; if (tx_ready[0] !== 1'b1) begin n_bad++; $display("FAIL m0_tx_ready: got %b want 1", tx_ready[0]); end
        n_cmp++; if (urn[0] - ub !== 0) begin n_bad++; $display("FAIL m0_no_underrun: got %0d want 0", urn[0] - ub); end
    endtask

    task automatic test_back_to_back();
        int rb, ub;
        rb = rxn[1]; ub = urn[1];
        f_n = 2; f_lp = 0;
        f_have[0] = 1; f_data[0] = 8'h01; f_ctrl[0] = 8'($urandom);
        f_have[1] = 1; f_data[1] = 8'h80; f_ctrl[1] = 8'($urandom);
        frame(1);
        n_cmp++; if (f_got[0] !== 8'h01) begin n_bad++; $display("FAIL m3_b2b_first: got %h want 01", f_got[0]); end
        n_cmp++; if (f_got[1] !== 8'h80) begin n_bad++; $display("FAIL m3_b2b_second: got %h want 80", f_got[1]); end
        n_cmp++; if (rxn[1] - rb !== 2) begin n_bad++; $display("FAIL m3_b2b_pulses: got %0d want 2", rxn[1] - rb); end
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (rxlog[1][(rb + k) % 64] !== f_ctrl[k]) begin
                n_bad++; $display("FAIL m3_b2b_rx%0d: got %h want %h", k, rxlog[1][(rb + k) % 64], f_ctrl[k]);
            end
        end
        n_cmp++; if (urn[1] - ub !== 0) begin n_bad++; $display("FAIL m3_b2b_underrun: got %0d want 0", urn[1] - ub); end
    endtask

    task automatic test_underrun();
        int rb, ub;
        rb = rxn[0]; ub = urn[0];
        f_n = 1; f_have[0] = 0; f_ctrl[0] = 8'($urandom); f_lp = 0;
        frame(0);
        n_cmp++; if (f_got[0] !== 8'hFF) begin n_bad++; $display("FAIL underrun_byte: got %h want ff", f_got[0]); end
        n_cmp++; if (urn[0] - ub !== 1) begin n_bad++; $display("FAIL underrun_pulses: got %0d want 1", urn[0] - ub); end
        n_cmp++; if (rxlog[0][rb % 64] !== f_ctrl[0] || rxn[0] - rb !== 1) begin
            n_bad++; $display("FAIL underrun_rx: got %h x%0d want %h x1", rxlog[0][rb % 64], rxn[0] - rb, f_ctrl[0]);
        end
    endtask

    task automatic test_abort();
        int rb;
        logic [7:0] c;
        c = 8'($urandom);
        push(0, 8'hC3);
        rb = rxn[0];
        cs[0] = 1'b0; pico[0] = c[7];
        half(0, 1'b0, 8'h00);
        for (int i = 7; i >= 3; i--) begin
            sclk[0] = 1'b1;
            half(0, 1'b0, 8'h00);
            sclk[0] = 1'b0;
            pico[0] = c[i - 1];
            half(0, 1'b0, 8'h00);
        end
        n_cmp++; if (poci_oe[0] !== 1'b1) begin n_bad++; $display("FAIL abort_oe_active: got %b want 1", poci_oe[0]); end
        cs[0] = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (poci_oe[0] !== 1'b0) begin n_bad++; $display("FAIL abort_oe_drop: got %b want 0", poci_oe[0]); end
        repeat (10) @(posedge clock);
        #1;
        n_cmp++; if (rxn[0] - rb !== 0) begin n_bad++; $display("FAIL abort_no_rx: got %0d pulses want 0", rxn[0] - rb); end
        rb = rxn[0];
        f_n = 1; f_have[0] = 1; f_data[0] = 8'($urandom); f_ctrl[0] = 8'($urandom); f_lp = 0;
        frame(0);
        n_cmp++; if (f_got[0] !== f_data[0]) begin n_bad++; $display("FAIL abort_next_tx: got %h want %h", f_got[0], f_data[0]); end
        n_cmp++; if (rxlog[0][rb % 64] !== f_ctrl[0]) begin n_bad++; $display("FAIL abort_next_rx: got %h want %h", rxlog[0][rb % 64], f_ctrl[0]); end
    endtask

    task automatic test_load_collision();
        int ub;
        ub = urn[0];
        f_n = 1; f_have[0] = 0; f_ctrl[0] = 8'($urandom); f_lp = 1; f_lpb = 8'h6E;
        frame(0);
        f_lp = 0;
        n_cmp++; if (f_got[0] !== 8'hFF) begin n_bad++; $display("FAIL collide_idle_byte: got %h want ff", f_got[0]); end
        n_cmp++; if (urn[0] - ub !== 1) begin n_bad++; $display("FAIL collide_underrun: got %0d want 1", urn[0] - ub); end
        n_cmp++; if (tx_ready[0] !== 1'b0) begin n_bad++; $display("FAIL collide_held: tx_ready got %b want 0", tx_ready[0]); end
        ub = urn[0];
        f_have[0] = 0; f_ctrl[0] = 8'($urandom);
        frame(0);
        n_cmp++; if (f_got[0] !== 8'h6E) begin n_bad++; $display("FAIL collide_next_frame: got %h want 6e", f_got[0]); end
        n_cmp++; if (urn[0] - ub !== 0) begin n_bad++; $display("FAIL collide_next_underrun: got %0d want 0", urn[0] - ub); end
    endtask

    task automatic test_random();
        int rb, ub, eu;
        for (int m = 0; m < 2; m++) begin
            for (int f = 0; f < 6; f++) begin
                rb = rxn[m]; ub = urn[m]; eu = 0;
                f_n = int'($urandom_range(1, 3)); f_lp = 0;
                for (int k = 0; k < 4; k++) begin
                    f_have[k] = 1'($urandom);
                    f_data[k] = 8'($urandom);
                    f_ctrl[k] = 8'($urandom);
                    if (k < f_n && !f_have[k]) eu++;
                end
                frame(m);
                for (int k = 0; k < f_n; k++) begin
                    n_cmp++;
                    if (f_got[k] !== (f_have[k] ? f_data[k] : 8'hFF)) begin
                        n_bad++; $display("FAIL rand_tx m%0d f%0d b%0d: got %h want %h", m, f, k, f_got[k], f_have[k] ? f_data[k] : 8'hFF);
                    end
                    n_cmp++;
                    if (rxlog[m][(rb + k) % 64] !== f_ctrl[k]) begin
                        n_bad++; $display("FAIL rand_rx m%0d f%0d b%0d: got %h want %h", m, f, k, rxlog[m][(rb + k) % 64], f_ctrl[k]);
                    end
                end
                n_cmp++;
                if (rxn[m] - rb !== f_n || urn[m] - ub !== eu) begin
                    n_bad++; $display("FAIL rand_counts m%0d f%0d: got rx=%0d un=%0d want rx=%0d un=%0d", m, f, rxn[m] - rb, urn[m] - ub, f_n, eu);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int rb;
        logic [7:0] c;
        c = 8'($urandom);
        push(0, 8'h11);
        cs[0] = 1'b0; pico[0] = c[7];
        half(0, 1'b0, 8'h00);
        for (int i = 7; i >= 5; i--) begin
            sclk[0] = 1'b1;
            half(0, i == 7, 8'h22);
            sclk[0] = 1'b0;
            pico[0] = c[i - 1];
            half(0, 1'b0, 8'h00);
        end
        n_cmp++; if ({tx_ready[0], poci_oe[0]} !== 2'b01) begin
            n_bad++; $display("FAIL midframe_state: got rdy=%b oe=%b want 0 1", tx_ready[0], poci_oe[0]);
        end
        rst_n[0] = 1'b0;
        @(posedge clock); #1;
        n_cmp++;
        if ({rx_data[0], rx_valid[0], tx_ready[0], tx_underrun[0], poci[0], poci_oe[0]} !== {8'h00, 5'b01010}) begin
            n_bad++;
            $display("FAIL midframe_reset: got rx=%h v=%b rdy=%b un=%b poci=%b oe=%b want 00 0 1 0 1 0",
                     rx_data[0], rx_valid[0], tx_ready[0], tx_underrun[0], poci[0], poci_oe[0]);
        end
        cs[0] = 1'b1; sclk[0] = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        rst_n[0] = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        rb = rxn[0];
        f_n = 1; f_have[0] = 1; f_data[0] = 8'h5A; f_ctrl[0] = 8'($urandom); f_lp = 0;
        frame(0);
        n_cmp++; if (f_got[0] !== 8'h5A) begin n_bad++; $display("FAIL post_reset_tx: got %h want 5a", f_got[0]); end
        n_cmp++; if (rxn[0] - rb !== 1 || rx_data[0] !== f_ctrl[0]) begin
            n_bad++; $display("FAIL post_reset_rx: got %h x%0d want %h x1", rx_data[0], rxn[0] - rb, f_ctrl[0]);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rxn[0] = 0; rxn[1] = 0; urn[0] = 0; urn[1] = 0;
        f_lp = 0; f_lpb = 8'h00; f_n = 1;
        for (int k = 0; k < 4; k++) begin
            f_ctrl[k] = 8'h00; f_data[k] = 8'h00; f_have[k] = 0; f_got[k] = 8'h00;
        end
        sclk = 2'b10; cs = 2'b11; pico = 2'b00; tx_valid = 2'b00;
        tx_data[0] = 8'h00; tx_data[1] = 8'h00;
        rst_n = 2'b00;
        test_reset();
        test_mode0_basic();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_load_collision();
        test_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
